// File: rtl/seq_det_frame_ctrl_if.sv
// Frame handshake bundle for seq_det_frame_ctrl.
// Carries the input frame handshake (in_valid/in_ready/in_word) and the result
// handshake (out_valid/out_ready/out_word/out_count).
// Frame vectors are declared [0:WORD_W-1] so that index 0 (the leftmost bit of
// a literal) is the first bit processed.
//   master : frame producer / result consumer (testbench, upstream logic)
//   slave  : the controller
interface seq_det_frame_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [0:WORD_W-1] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [0:WORD_W-1] out_word;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_count
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_count
  );
endinterface

// File: rtl/seq_det_frame_ctrl.sv
// Frame-level serial pattern detector.
// Accepts one WORD_W-bit frame, shifts it bit by bit (index 0 first) through a
// 4-bit match window, records a per-bit hit word and a hit count, then holds
// the result until the consumer takes it.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cfg_pattern  4-bit target; bit 3 = oldest of the last 4 bits, bit 0 = newest
//   cfg_overlap  1 = overlapping matches, 0 = history restarts after each hit
//   bus          frame/result handshake bundle (slave side)
//   busy         high while a frame is running or a result is held
module seq_det_frame_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_pattern,
  input  logic                  cfg_overlap,
  seq_det_frame_ctrl_if.slave   bus,
  output logic                  busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [0:WORD_W-1] out_word_r;
  logic [CNT_W-1:0]  out_count_r;
  logic [0:WORD_W-1] word_r;
  logic [3:0]        pat_r;
  logic              ovl_r;
  // Only the three most recent bits need storing; the fourth is the live bit.
  logic [2:0]        hist_r;
  logic [2:0]        fill_r;
  logic [IDX_W-1:0]  idx_r;

  logic              bit_s;
  logic [3:0]        window_s;
  logic              hit_s;
  logic [2:0]        fill_next_s;

  // Match datapath for the bit currently addressed by idx.
  always_comb begin
    bit_s    = word_r[idx_r];
    window_s = {hist_r, bit_s};
    // fill+1 >= 4 means the window holds four bits of this frame
    if (fill_r >= 3'd3) begin
      hit_s = (window_s == pat_r);
    end else begin
      hit_s = 1'b0;
    end
    if (fill_r >= 3'd4) begin
      fill_next_s = 3'd4;
    end else begin
      fill_next_s = fill_r + 3'd1;
    end
  end

  // Frame sequencer with registered handshake, result and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_word_r  <= '0;
      out_count_r <= '0;
      word_r      <= '0;
      pat_r       <= 4'b0000;
      ovl_r       <= 1'b0;
      hist_r      <= 3'b000;
      fill_r      <= 3'd0;
      idx_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            // Shadow the frame and its configuration; start from a clean history.
            word_r      <= bus.in_word;
            pat_r       <= cfg_pattern;
            ovl_r       <= cfg_overlap;
            hist_r      <= 3'b000;
            fill_r      <= 3'd0;
            idx_r       <= '0;
            out_word_r  <= '0;
            out_count_r <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= RUN;
          end else begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        RUN: begin
          hist_r            <= window_s[2:0];
          out_word_r[idx_r] <= hit_s;
          if (hit_s) begin
            out_count_r <= out_count_r + CNT_W'(1);
          end else begin
            out_count_r <= out_count_r;
          end
          // Non-overlap mode: a hit consumes its bits, so require 4 fresh ones.
          if (hit_s && !ovl_r) begin
            fill_r <= 3'd0;
          end else begin
            fill_r <= fill_next_s;
          end
          if (idx_r == LAST_IDX) begin
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        HOLD: begin
          // in_valid is deliberately ignored here, even on the releasing edge.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_word  = out_word_r;
  assign bus.out_count = out_count_r;
  assign busy          = busy_r;

endmodule
